// File: rtl/router_pkg.sv
// Shared types and constants for the router ingress queue.
package router_pkg;

  localparam int unsigned DEST_W     = 2;
  localparam int unsigned DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDrain,
    StRearm
  } state_e;

  typedef struct packed {
    logic [DEST_W-1:0]     dest;
    logic [DATA_W_DEF-1:0] data;
  } packet_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy; DEPTH must be a power of two.
module sync_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3,
  parameter int unsigned WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             push_en, pop_en;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  // A pop on the same cycle does not free a slot for a push into a full FIFO.
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/router_ingress_queue.sv
// Buffers {dest, data} packets and issues them one at a time, paced by the
// router's ready_in fall/rise handshake.
module router_ingress_queue
  import router_pkg::*;
#(
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AW      = 3,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [DEST_W-1:0] in_dest,
  output logic              in_ready,
  input  logic              ready_in,
  output logic              pkt_valid,
  output logic [DATA_W-1:0] pkt_data,
  output logic [DEST_W-1:0] pkt_dest,
  output logic [AW:0]       fifo_count,
  output logic [15:0]       sent_count,
  output logic              err_timeout
);

  localparam int unsigned PW = DEST_W + DATA_W;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [TW-1:0]     timer_q;
  logic [DATA_W-1:0] data_q;
  logic [DEST_W-1:0] dest_q;
  logic [15:0]       sent_q;
  logic              err_q;
  logic              full, empty, push, pop, timed_out;
  logic [PW-1:0]     head;

  assign in_ready = !full;
  assign push     = in_valid && in_ready;

  sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .WIDTH (PW)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata ({in_dest, in_data}),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Last DRAIN cycle the router may still hold ready_in high.
  assign timed_out = ready_in && (timer_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!empty && ready_in) state_d = StIssue;
      StIssue: state_d = StDrain;
      StDrain: begin
        if (!ready_in)      state_d = StRearm;
        else if (timed_out) state_d = StIdle;
      end
      StRearm: if (ready_in) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pop       = (state_q == StIdle) && !empty && ready_in;
    pkt_valid = (state_q == StIssue);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      data_q  <= '0;
      dest_q  <= '0;
      sent_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      if (state_q == StIssue)      timer_q <= '0;
      else if (state_q == StDrain) timer_q <= timer_q + TW'(1);
      if (pop) {dest_q, data_q} <= head;
      if (state_q == StIssue) sent_q <= sent_q + 16'd1;
      if (state_q == StDrain && timed_out) err_q <= 1'b1;
    end
  end

  assign pkt_data    = data_q;
  assign pkt_dest    = dest_q;
  assign sent_count  = sent_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_router_ingress_queue.sv
// Randomised bench for router_ingress_queue against a packet-queue reference
// model plus a simple router that drops ready_in two cycles after each issue.
module tb_router_ingress_queue;
  import router_pkg::*;

  localparam int DEPTH = 8;
  localparam int ModeNormal = 0;
  localparam int ModeStall  = 1;
  localparam int ModeHigh   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic [1:0]  in_dest = '0;
  logic        in_ready;
  logic        ready_in = 1'b1;
  logic        pkt_valid;
  logic [7:0]  pkt_data;
  logic [1:0]  pkt_dest;
  logic [3:0]  fifo_count;
  logic [15:0] sent_count;
  logic        err_timeout;

  always #5 clk = ~clk;

  router_ingress_queue dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_dest     (in_dest),
    .in_ready    (in_ready),
    .ready_in    (ready_in),
    .pkt_valid   (pkt_valid),
    .pkt_data    (pkt_data),
    .pkt_dest    (pkt_dest),
    .fifo_count  (fifo_count),
    .sent_count  (sent_count),
    .err_timeout (err_timeout)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state
  packet_t     exp_q[$];
  packet_t     held;
  int          model_count, cyc, mode, n_pulses;
  int          last_pulse, prev_pulse, low_start, low_end, err_cycle;
  logic [15:0] sent_model;
  logic        err_model;

  task automatic clear_model();
    exp_q.delete();
    held        = '0;
    model_count = 0;
    sent_model  = '0;
    err_model   = 1'b0;
    last_pulse  = -1;
    prev_pulse  = -1;
    low_start   = -1;
    low_end     = -2;
    err_cycle   = -1;
  endtask

  task automatic step(input logic v, input logic [7:0] d, input logic [1:0] dst);
    logic    acc;
    packet_t p;
    in_valid = v;
    in_data  = d;
    in_dest  = dst;
    case (mode)
      ModeStall: ready_in = 1'b0;
      ModeHigh:  ready_in = 1'b1;
      default:   ready_in = !(cyc >= low_start && cyc <= low_end);
    endcase
    check("in_ready", in_ready, model_count != DEPTH);
    acc = v && (model_count != DEPTH);
    @(posedge clk);
    #1;
    cyc++;
    if (acc) begin
      p.dest = dst;
      p.data = d;
      exp_q.push_back(p);
      model_count++;
    end
    if (cyc == err_cycle) err_model = 1'b1;
    check("sent_count", sent_count, sent_model);
    if (pkt_valid) begin
      check("pulse_has_packet", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        held = exp_q.pop_front();
        model_count--;
      end
      sent_model++;
      n_pulses++;
      if (mode == ModeNormal && last_pulse >= 0) check("spacing_ge5", (cyc - last_pulse) >= 5, 1);
      prev_pulse = last_pulse;
      last_pulse = cyc;
      if (mode == ModeNormal) begin
        low_start = cyc + 2;
        low_end   = cyc + 1 + int'($urandom_range(1, 3));
      end
      if (mode == ModeHigh) err_cycle = cyc + 9;
    end
    check("pkt_data", pkt_data, held.data);
    check("pkt_dest", pkt_dest, held.dest);
    check("fifo_count", fifo_count, model_count);
    check("err_timeout", err_timeout, err_model);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 2'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) step(1'b0, 8'h00, 2'd0);
    check("drain_empty", exp_q.size(), 0);
    idle(8);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    ready_in = 1'b1;
    rst_n    = 1'b0;
    #1;
    check("rst_fifo_count", fifo_count, 0);
    check("rst_pkt_valid", pkt_valid, 0);
    check("rst_sent", sent_count, 0);
    check("rst_err", err_timeout, 0);
    check("rst_pkt_data", pkt_data, 0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_no_pulse", pkt_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    @(posedge clk);
    #1;
    cyc++;
    check("rst_in_ready", in_ready, 1);
    check("rst_count_after", fifo_count, 0);
    check("rst_pkt_dest", pkt_dest, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, base;
    cyc      = 0;
    n_pulses = 0;
    mode     = ModeNormal;
    clear_model();
    do_reset();

    // Single packet latency and pulse width
    idle(2);
    c = cyc;
    step(1'b1, 8'hA5, 2'd2);
    step(1'b0, 8'h00, 2'd0);
    check("lat_pulse", pkt_valid, 1);
    check("lat_cycles", last_pulse - c, 2);
    check("single_data", pkt_data, 8'hA5);
    check("single_dest", pkt_dest, 2);
    step(1'b0, 8'h00, 2'd0);
    check("pulse_width", pkt_valid, 0);
    check("single_sent", sent_count, 1);
    idle(8);

    // Burst while router stalled, then release
    mode = ModeStall;
    for (int i = 0; i < 8; i++) step(1'b1, 8'h10 + 8'(i), 2'(i));
    check("burst_full_count", fifo_count, 8);
    check("burst_full_ready", in_ready, 0);
    step(1'b1, 8'h99, 2'd3);
    check("ninth_ignored", fifo_count, 8);
    mode = ModeNormal;
    base = n_pulses;
    drain();
    check("burst_pulses", n_pulses - base, 8);

    // Simultaneous push and pop at count 1
    mode = ModeStall;
    step(1'b1, 8'h55, 2'd1);
    check("sim_pre_count", fifo_count, 1);
    mode = ModeNormal;
    step(1'b1, 8'h66, 2'd3);
    check("sim_pulse", pkt_valid, 1);
    check("sim_count", fifo_count, 1);
    drain();

    // Random traffic; wraps the pointers several times
    base = n_pulses;
    for (int i = 0; i < 250; i++)
      step($urandom_range(0, 9) < 6, 8'($urandom), 2'($urandom));
    drain();
    check("rand_pulses_ge20", (n_pulses - base) >= 20, 1);

    // Timeout with ready_in stuck high; queued packet still issues
    mode = ModeHigh;
    idle(2);
    step(1'b1, 8'h3C, 2'd1);
    step(1'b1, 8'h3D, 2'd3);
    idle(12);
    check("to_err", err_timeout, 1);
    check("to_gap", last_pulse - prev_pulse, 10);
    check("to_second_data", pkt_data, 8'h3D);
    idle(12);

    // Reset mid-stream with 3 queued; clears sticky error
    mode = ModeStall;
    for (int i = 0; i < 3; i++) step(1'b1, 8'hC0 + 8'(i), 2'(i));
    check("pre_rst_count", fifo_count, 3);
    do_reset();
    mode = ModeNormal;
    idle(4);

    // sent_count wrap
    force dut.sent_q = 16'hFFFE;
    sent_model = 16'hFFFE;
    #1;
    release dut.sent_q;
    step(1'b1, 8'h01, 2'd0);
    idle(8);
    check("sent_ffff", sent_count, 16'hFFFF);
    step(1'b1, 8'h02, 2'd1);
    idle(8);
    check("sent_wrap", sent_count, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/router_ingress_queue.md
Name: router_ingress_queue

Overview:
- Upstream feeder for the 1x4 router stage.
- Buffers incoming {dest, data} packets from the source in a small FIFO.
- Issues each packet to the router as a single-cycle pkt_valid pulse.
- Uses the router's ready_in drop/rise cycle to pace issues, so no packet is delivered twice or lost while the router is busy.

Parameters:
- DEPTH, 8, FIFO entries (power of two, >=2)
- AW, 3, log2(DEPTH)
- DATA_W, 8, payload width
- TIMEOUT, 8, cycles to wait for router ready_in to fall after an issue

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  source offers a packet
- in_data  in  DATA_W  source payload
- in_dest  in  2  source destination port 0..3
- in_ready  out  1  queue can accept (not full)
- ready_in  in  1  router ready, driven by router
- pkt_valid  out  1  one-cycle issue strobe to router
- pkt_data  out  DATA_W  payload to router data_in
- pkt_dest  out  2  destination to router dest_addr
- fifo_count  out  AW+1  current occupancy 0..DEPTH
- sent_count  out  16  packets issued, wraps at 16'hFFFF->0
- err_timeout  out  1  sticky: router never dropped ready_in after an issue

Behaviour:
- Reset (rst_n=0, async): FIFO empty, rd/wr pointers 0, fifo_count=0, state IDLE, pkt_valid=0, pkt_data=0, pkt_dest=0, sent_count=0, err_timeout=0. in_ready=1 once reset is released. Reset mid-transfer discards all queued packets; no pkt_valid pulse is emitted while reset is asserted.
- in_ready = (fifo_count != DEPTH), combinational from registered count.
- Push occurs when in_valid && in_ready. {in_dest, in_data} is written at wr_ptr; wr_ptr wraps modulo DEPTH.
- in_valid while full: ignored, nothing written. The source must hold the packet until in_ready=1.
- Pop occurs on the IDLE->ISSUE transition. The head is copied into the pkt_data/pkt_dest registers; rd_ptr wraps modulo DEPTH.
- Simultaneous push and pop: both happen and fifo_count is unchanged. Push is still blocked if full at that cycle, even though a pop occurs.
- FSM states: IDLE, ISSUE, DRAIN, REARM.
  - IDLE: if fifo_count!=0 && ready_in, go to ISSUE (pop). Otherwise stay.
  - ISSUE: pkt_valid=1 for exactly this one cycle; sent_count increments. Always go to DRAIN.
  - DRAIN: wait for ready_in=0, then go to REARM. A cycle counter increments each DRAIN cycle. When the count reaches TIMEOUT with ready_in still 1, set err_timeout and go to IDLE. The packet is considered lost; no retry.
  - REARM: wait for ready_in=1, then go to IDLE. No timeout.
- pkt_valid = (state==ISSUE), decoded from the state register, glitch-free.
- pkt_data/pkt_dest hold their value until the next pop.
- Latency: a packet pushed into an empty queue with ready_in=1 appears on pkt_valid 2 cycles after the push edge (push edge, then IDLE->ISSUE edge).
- Issue spacing: at most one issue per router ready_in low/high cycle. With the router's ready_in falling 2 cycles after acceptance, back-to-back issues are >=5 cycles apart.
- ready_in falling while in IDLE causes no action. ready_in re-rising in DRAIN before it was seen low is not possible to detect and is covered by the timeout.
- err_timeout clears only on reset.
- sent_count wraps silently.

Decomposition:
- Shared package router_pkg:
  - FSM state encoding (IDLE/ISSUE/DRAIN/REARM, 2 bits)
  - dest width constant 2, DATA_W default
  - packet struct {dest[1:0], data[DATA_W-1:0]}
- Sub-module sync_fifo (DEPTH, width 2+DATA_W) containing the memory, pointers, and count; exposes full/empty/count.
- FSM, timeout counter, output registers, and sent_count live in router_ingress_queue.

Test Plan:
- Reset/idle: rst_n=0 mid-stream with 3 entries queued -> after release fifo_count=0, pkt_valid=0, sent_count=0, in_ready=1.
- Single packet, router model with ready_in drop 2 cycles after accept: push data=8'hA5, dest=2 -> pkt_valid pulse exactly 1 cycle, 2 cycles after push, pkt_data=A5, pkt_dest=2, sent_count=1.
- Burst 8 packets (data 0x10..0x17, dest 0,1,2,3,0,1,2,3) with router stalled -> fifo_count=8, in_ready=0; a 9th push is ignored. After release, 8 pulses in order, >=5 cycles apart, pkt_dest sequence matches, no duplicates.
- Simultaneous push/pop at count=1 -> count stays 1; wrap past index 7 preserves FIFO order for 20 packets.
- Timeout: ready_in tied 1 and one packet pushed -> one pulse, then err_timeout=1 after 8 DRAIN cycles. State returns to IDLE and the next queued packet issues.
- sent_count wrap: preload via 65536 issues (or force) -> the counter reads 0 after 16'hFFFF.
